padframe_cfg_seq: RTL and testbench
===================================

# padframe_cfg_seq

Parametrised configuration sequencer for the bidirectional pad ring. It holds a per-pad shadow configuration written over a simple addressed bus, then commits it to the live pad control buses (CS/SL/IE/OE/PU/PD/PDRV0/PDRV1) one pad at a time. Pads whose output enable changes are followed by a programmable settle gap, which limits simultaneous-switching noise. It sits in the core between the test controller and the half-frame bidir pad array, and drives that array's control inputs directly.

## Interface
Parameters:
- `NUM_PADS`, 46: number of bidir pads controlled (1..64).
- `STAGGER`, 4: idle cycles inserted after committing a pad whose OE changes (0..255).
- `RESET_CFG`, 8'h04: per-pad reset configuration byte (IE=1, everything else 0).

Ports (clock and reset first; one clock, reset is asynchronous and active-high):
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous active-high reset.
- `cfg_wr`  in  1  write strobe for the shadow register.
- `cfg_addr`  in  6  pad index.
- `cfg_wdata`  in  8  config byte: [0]CS [1]SL [2]IE [3]OE [4]PU [5]PD [6]PDRV0 [7]PDRV1.
- `cfg_commit`  in  1  start a commit sequence.
- `cfg_ready`  out  1  high in IDLE; writes and commits are accepted only while high.
- `cfg_busy`  out  1  high during a commit sequence.
- `cfg_done`  out  1  one-cycle pulse when a commit sequence finishes.
- `cfg_err`  out  1  sticky; set by a write to `cfg_addr` >= NUM_PADS; cleared on an accepted commit.
- `bidir_CS`, `bidir_SL`, `bidir_IE`, `bidir_OE`, `bidir_PU`, `bidir_PD`, `bidir_PDRV0`, `bidir_PDRV1`  out  NUM_PADS each  live pad controls, bit i drives pad i.
- `cfg_rdata`  out  8  readback; present only with CFG_READBACK_EN.

## Operation
- Storage: shadow[NUM_PADS] x 8 and active[NUM_PADS] x 8. Both reset to RESET_CFG. Pad outputs are decoded combinationally from active.
- States:
  - IDLE: `cfg_ready`=1. A write with `cfg_wr` and a valid address updates shadow[addr] on the next edge.
  - APPLY: idx runs from 0 to NUM_PADS-1. Each cycle copies shadow[idx] to active[idx].
    - If bit3 (OE) differs between old and new, go to GAP.
    - Otherwise increment idx.
    - After the last pad, go to DONE.
  - GAP: counts STAGGER cycles, then resumes APPLY at idx+1, or goes to DONE if idx was last. With STAGGER=0 the GAP state is skipped entirely.
  - DONE: one cycle with `cfg_done`=1, then IDLE.
- `cfg_commit` in IDLE: enter APPLY at idx 0 and clear `cfg_err`.
- Write and commit in the same IDLE cycle: the write lands in shadow first, and the commit includes it.
- Writes or commits outside IDLE are ignored with no side effects (`cfg_ready`=0).
- Invalid-address write: shadow is unchanged and `cfg_err` is set.
- Reset mid-sequence: all active and shadow entries return to RESET_CFG, state goes to IDLE, and `cfg_err` is cleared.

## Timing
- Reset values:
  - `cfg_ready`=1, `cfg_busy`=0, `cfg_done`=0, `cfg_err`=0.
  - `bidir_IE`=all ones; every other pad control bus is all zeros.
  - `cfg_rdata`=RESET_CFG.
- Shadow write latency: 1 cycle.
- Commit:
  - Accepted at edge T.
  - `cfg_busy` rises at T+1.
  - Pad i changes at the edge ending its APPLY cycle.
  - Total length is NUM_PADS + STAGGER·(number of OE-changing pads) cycles of APPLY/GAP, plus 1 DONE cycle.
  - `cfg_ready` returns the cycle after DONE.
- Order guarantee: pads update strictly in ascending index. There are never two OE transitions fewer than STAGGER+1 cycles apart within one commit.

## Configuration
- `CFG_READBACK_EN` defined:
  - `cfg_rdata` port is present.
  - Registered read of active[cfg_addr], valid 1 cycle after the address is presented.
  - Out-of-range addresses read 8'h00.
- Undefined: no `cfg_rdata` port and no read mux; all other behaviour is identical.

## Test plan
- Reset, NUM_PADS=46: `bidir_IE`=46'h3FFF_FFFF_FFFF, all other buses 0, `cfg_ready`=1.
- Write pad 5 = 8'h0C (IE|OE), then commit, STAGGER=4: `bidir_OE[5]` rises in APPLY cycle 6. Sequence length is 46+4 cycles, then `cfg_done` pulses exactly once.
- Write pads 0 and 1 = 8'h0C, then commit: the OE rises on pads 0 and 1 are exactly 5 cycles apart. Writes attempted during `cfg_busy` leave shadow unchanged.
- Write to `cfg_addr`=50: `cfg_err`=1 and shadow is unchanged. The next commit clears `cfg_err`, and all pads end at RESET_CFG.
- Assert `rst` during GAP after pad 3's OE enable: `bidir_OE`=0 immediately (asynchronously) and the state is IDLE. A following commit with an untouched shadow produces no pad changes and takes 46 APPLY cycles plus 1 DONE cycle.
- With CFG_READBACK_EN, after committing pad 7 = 8'hF0: `cfg_addr`=7 returns 8'hF0 one cycle later, and `cfg_addr`=60 returns 8'h00.

Source files
------------

// File: rtl/padframe_cfg_seq.sv
// padframe_cfg_seq: configuration sequencer for the bidirectional pad ring.
//
// Holds a per-pad shadow configuration byte that is written over a simple addressed bus.
// On a commit, the shadow is copied into the live (active) configuration one pad at a time,
// in ascending pad index. After each pad whose output enable changes, the sequencer waits
// STAGGER idle cycles to limit simultaneous-switching noise.
//
// Config byte layout: [0]CS [1]SL [2]IE [3]OE [4]PU [5]PD [6]PDRV0 [7]PDRV1
//
// Ports:
//   clk, rst            core clock; asynchronous active-high reset
//   cfg_wr/addr/wdata   shadow write strobe, pad index, config byte
//   cfg_commit          start a commit sequence (accepted only while cfg_ready)
//   cfg_ready           high in idle; writes and commits are accepted only then
//   cfg_busy            high from the cycle after an accepted commit through the done cycle
//   cfg_done            one-cycle pulse marking the end of a commit sequence
//   cfg_err             sticky flag for out-of-range writes; cleared by an accepted commit
//   bidir_*             live pad control buses, bit i drives pad i
//   cfg_rdata           registered readback of active[cfg_addr] (CFG_READBACK_EN only)
//
// Optional feature macro: CFG_READBACK_EN adds the cfg_rdata port and its read mux.
module padframe_cfg_seq #(
    parameter int unsigned NUM_PADS  = 46,
    parameter int unsigned STAGGER   = 4,
    parameter logic [7:0]  RESET_CFG = 8'h04
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_wr,
    input  logic [5:0]          cfg_addr,
    input  logic [7:0]          cfg_wdata,
    input  logic                cfg_commit,
    output logic                cfg_ready,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic [NUM_PADS-1:0] bidir_CS,
    output logic [NUM_PADS-1:0] bidir_SL,
    output logic [NUM_PADS-1:0] bidir_IE,
    output logic [NUM_PADS-1:0] bidir_OE,
    output logic [NUM_PADS-1:0] bidir_PU,
    output logic [NUM_PADS-1:0] bidir_PD,
    output logic [NUM_PADS-1:0] bidir_PDRV0,
    output logic [NUM_PADS-1:0] bidir_PDRV1
`ifdef CFG_READBACK_EN
    ,
    output logic [7:0]          cfg_rdata
`endif
);

    typedef enum logic [1:0] {StIdle, StApply, StGap, StDone} state_e;

    localparam logic [5:0] LastIdx = 6'(NUM_PADS - 1);
    localparam logic [7:0] GapInit = 8'(STAGGER - 1);

    state_e     state_q;
    logic [5:0] idx_q;
    logic [7:0] gap_q;
    logic       ready_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic [7:0] shadow_q [NUM_PADS];
    logic [7:0] active_q [NUM_PADS];

    logic addr_ok;
    logic last_pad;
    logic oe_chg;

    assign addr_ok  = ({1'b0, cfg_addr} < 7'(NUM_PADS));
    assign last_pad = (idx_q == LastIdx);
    // OE toggles when the incoming shadow byte disagrees with the live one.
    assign oe_chg   = shadow_q[idx_q][3] ^ active_q[idx_q][3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            gap_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_PADS; i++) begin
                shadow_q[i] <= RESET_CFG;
                active_q[i] <= RESET_CFG;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cfg_commit) begin
                        state_q <= StApply;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                    // Placed after the commit so a same-cycle bad write still flags an error.
                    if (cfg_wr) begin
                        if (addr_ok) begin
                            shadow_q[cfg_addr] <= cfg_wdata;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StApply: begin
                    active_q[idx_q] <= shadow_q[idx_q];
                    if (oe_chg && (STAGGER != 0)) begin
                        state_q <= StGap;
                        gap_q   <= GapInit;
                    end else if (last_pad) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                StGap: begin
                    if (gap_q == 8'd0) begin
                        if (last_pad) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StApply;
                            idx_q   <= idx_q + 6'd1;
                        end
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

    always_comb begin
        bidir_CS    = '0;
        bidir_SL    = '0;
        bidir_IE    = '0;
        bidir_OE    = '0;
        bidir_PU    = '0;
        bidir_PD    = '0;
        bidir_PDRV0 = '0;
        bidir_PDRV1 = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            bidir_CS[i]    = active_q[i][0];
            bidir_SL[i]    = active_q[i][1];
            bidir_IE[i]    = active_q[i][2];
            bidir_OE[i]    = active_q[i][3];
            bidir_PU[i]    = active_q[i][4];
            bidir_PD[i]    = active_q[i][5];
            bidir_PDRV0[i] = active_q[i][6];
            bidir_PDRV1[i] = active_q[i][7];
        end
    end

`ifdef CFG_READBACK_EN
    logic [7:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= RESET_CFG;
        end else begin
            rdata_q <= addr_ok ? active_q[cfg_addr] : 8'h00;
        end
    end

    assign cfg_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_padframe_cfg_seq.sv
// Self-checking bench for padframe_cfg_seq: directed scenarios plus randomized write/commit
// rounds, compared against a schedule-based reference model of the pad configuration.
module tb_padframe_cfg_seq;

    localparam int unsigned NP = 46;
    localparam int unsigned ST = 4;
    localparam logic [7:0]  RC = 8'h04;

    typedef logic [7:0] cfg_arr_t [NP];

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_wr;
    logic [5:0]    cfg_addr;
    logic [7:0]    cfg_wdata;
    logic          cfg_commit;
    logic          cfg_ready;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_err;
    logic [NP-1:0] bidir_CS, bidir_SL, bidir_IE, bidir_OE;
    logic [NP-1:0] bidir_PU, bidir_PD, bidir_PDRV0, bidir_PDRV1;
`ifdef CFG_READBACK_EN
    logic [7:0]    cfg_rdata;
`endif

    padframe_cfg_seq #(
        .NUM_PADS  (NP),
        .STAGGER   (ST),
        .RESET_CFG (RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_ready   (cfg_ready),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .bidir_CS    (bidir_CS),
        .bidir_SL    (bidir_SL),
        .bidir_IE    (bidir_IE),
        .bidir_OE    (bidir_OE),
        .bidir_PU    (bidir_PU),
        .bidir_PD    (bidir_PD),
        .bidir_PDRV0 (bidir_PDRV0),
        .bidir_PDRV1 (bidir_PDRV1)
`ifdef CFG_READBACK_EN
        ,
        .cfg_rdata   (cfg_rdata)
`endif
    );

    always #5 clk = ~clk;

    logic [NP-1:0] obs_bus [8];
    assign obs_bus[0] = bidir_CS;
    assign obs_bus[1] = bidir_SL;
    assign obs_bus[2] = bidir_IE;
    assign obs_bus[3] = bidir_OE;
    assign obs_bus[4] = bidir_PU;
    assign obs_bus[5] = bidir_PD;
    assign obs_bus[6] = bidir_PDRV0;
    assign obs_bus[7] = bidir_PDRV1;

    int checks   = 0;
    int failures = 0;

    cfg_arr_t m_shadow;
    cfg_arr_t m_active;
    logic     m_err;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_pads(input string tag, input cfg_arr_t v);
        logic [63:0] e;
        for (int b = 0; b < 8; b++) begin
            e = '0;
            for (int i = 0; i < NP; i++) e[i] = v[i][b];
            check_eq($sformatf("%s bus%0d", tag, b), 64'(obs_bus[b]), e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_shadow[i] = RC;
            m_active[i] = RC;
        end
        m_err = 1'b0;
    endtask

    task automatic idle_write(input logic [5:0] a, input logic [7:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        if (int'(a) < NP) m_shadow[a] = d;
        else m_err = 1'b1;
        check_eq("err after write", 64'(cfg_err), 64'(m_err));
    endtask

    // Commit from idle; optional same-cycle valid write; optional junk traffic while busy.
    task automatic do_commit(input bit wr_too, input logic [5:0] a, input logic [7:0] d,
                             input bit junk);
        int       ap [NP];
        int       len;
        cfg_arr_t cur;
        if (wr_too) m_shadow[a] = d;
        // Pad i is applied in cycle ap[i]; OE changes add a gap after that pad.
        len = 0;
        for (int i = 0; i < NP; i++) begin
            ap[i] = len + 1;
            len   = len + 1;
            if (m_shadow[i][3] != m_active[i][3]) len = len + ST;
        end
        cfg_wr     = wr_too;
        cfg_addr   = a;
        cfg_wdata  = d;
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
        m_err      = 1'b0;
        for (int c = 1; c <= len + 1; c++) begin
            for (int i = 0; i < NP; i++) cur[i] = (ap[i] < c) ? m_shadow[i] : m_active[i];
            check_pads($sformatf("commit cyc%0d", c), cur);
            if (c <= len) begin
                check_eq("busy in seq", 64'(cfg_busy), 64'd1);
                check_eq("ready in seq", 64'(cfg_ready), 64'd0);
                check_eq("done in seq", 64'(cfg_done), 64'd0);
            end else begin
                check_eq("done pulse", 64'(cfg_done), 64'd1);
            end
            if (junk) begin
                cfg_wr     = 1'($urandom);
                cfg_addr   = 6'($urandom_range(0, NP - 1));
                cfg_wdata  = 8'($urandom);
                cfg_commit = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
        check_eq("ready after", 64'(cfg_ready), 64'd1);
        check_eq("busy after", 64'(cfg_busy), 64'd0);
        check_eq("done after", 64'(cfg_done), 64'd0);
        check_eq("err after commit", 64'(cfg_err), 64'(m_err));
        m_active = m_shadow;
    endtask

    initial begin
        int n;
        cfg_wr     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        cfg_commit = 1'b0;
        rst        = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check_eq("rst ready", 64'(cfg_ready), 64'd1);
        check_eq("rst busy", 64'(cfg_busy), 64'd0);
        check_eq("rst done", 64'(cfg_done), 64'd0);
        check_eq("rst err", 64'(cfg_err), 64'd0);
        check_eq("rst IE", 64'(bidir_IE), 64'h3FFF_FFFF_FFFF);
        check_pads("rst", m_active);
`ifdef CFG_READBACK_EN
        check_eq("rst rdata", 64'(cfg_rdata), 64'(RC));
`endif

        // Single OE-changing pad
        idle_write(6'd5, 8'h0C);
        do_commit(1'b0, 6'd0, 8'h00, 1'b0);

        // Two adjacent OE changes, with ignored traffic while busy
        idle_write(6'd0, 8'h0C);
        idle_write(6'd1, 8'h0C);
        do_commit(1'b0, 6'd0, 8'h00, 1'b1);
        do_commit(1'b0, 6'd0, 8'h00, 1'b0);

        // Out-of-range write, then return everything to reset config
        idle_write(6'd50, 8'hFF);
        check_eq("err set", 64'(cfg_err), 64'd1);
        for (int i = 0; i < NP; i++) idle_write(6'(i), RC);
        do_commit(1'b0, 6'd0, 8'h00, 1'b0);
        check_pads("back to reset", m_shadow);

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                idle_write(6'($urandom_range(0, 63)), 8'($urandom));
            end
            do_commit(1'($urandom), 6'($urandom_range(0, NP - 1)), 8'($urandom), 1'b1);
        end

        // Reset during the gap following pad 3's OE enable
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        idle_write(6'd3, 8'h0C);
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("gap OE before rst", 64'(bidir_OE), 64'h8);
        check_eq("gap busy before rst", 64'(cfg_busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async rst OE", 64'(bidir_OE), 64'h0);
        check_eq("async rst IE", 64'(bidir_IE), 64'h3FFF_FFFF_FFFF);
        check_eq("async rst ready", 64'(cfg_ready), 64'd1);
        check_eq("async rst busy", 64'(cfg_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_commit(1'b0, 6'd0, 8'h00, 1'b0);

`ifdef CFG_READBACK_EN
        idle_write(6'd7, 8'hF0);
        do_commit(1'b0, 6'd0, 8'h00, 1'b0);
        cfg_addr = 6'd7;
        @(posedge clk); #1;
        check_eq("rdata pad7", 64'(cfg_rdata), 64'hF0);
        cfg_addr = 6'd60;
        @(posedge clk); #1;
        check_eq("rdata oob", 64'(cfg_rdata), 64'h00);
        cfg_addr = 6'd3;
        @(posedge clk); #1;
        check_eq("rdata pad3", 64'(cfg_rdata), 64'(m_active[3]));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
